// File: rtl/board_pkg.sv
// Shared definitions for the board write master: cell and result encodings,
// FSM state type, and neighbour address helper.
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BLACK = 2'd1;
    localparam logic [1:0] CELL_WHITE = 2'd2;

    localparam logic [2:0] RES_OK        = 3'd0;
    localparam logic [2:0] RES_OCCUPIED  = 3'd1;
    localparam logic [2:0] RES_SUICIDE   = 3'd2;
    localparam logic [2:0] RES_PASS      = 3'd3;
    localparam logic [2:0] RES_GAME_OVER = 3'd4;

    // Widest address the helper can return; callers truncate to 2*E bits.
    localparam int unsigned NBR_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOOK0,
        ST_LOOK1,
        ST_LOOK2,
        ST_COMMIT,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        DIR_C,
        DIR_N,
        DIR_S,
        DIR_W,
        DIR_E
    } dir_e;

    // Returns {valid, addr}; an off-board neighbour yields valid=0 and the target address.
    function automatic logic [NBR_ADDR_W:0] nbr_addr(input int unsigned x,
                                                     input int unsigned y,
                                                     input dir_e        dir,
                                                     input int unsigned edge_bits);
        int unsigned side;
        int unsigned nx;
        int unsigned ny;
        logic        ok;
        side = 1 << edge_bits;
        nx   = x;
        ny   = y;
        ok   = 1'b1;
        case (dir)
            DIR_N: if (y == 0)        ok = 1'b0; else ny = y - 1;
            DIR_S: if (y == side - 1) ok = 1'b0; else ny = y + 1;
            DIR_W: if (x == 0)        ok = 1'b0; else nx = x - 1;
            DIR_E: if (x == side - 1) ok = 1'b0; else nx = x + 1;
            default: ;
        endcase
        return {ok, NBR_ADDR_W'((ny << edge_bits) | nx)};
    endfunction

endpackage

// File: rtl/board_clear_sweeper.sv
// Address counter for the full-board clear sweep; wraps back to zero so the
// next sweep always starts at cell 0.
module board_clear_sweeper #(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (en) begin
            addr <= addr + ADDR_BITS'(1);
        end
    end

    assign done = en && (addr == '1);

endmodule

// File: rtl/board_move_writer.sv
// Single write master for the board state RAM: clear sweep, move lookup and commit.
// Define SUICIDE_CHECK_EN to reject placements with no empty on-board neighbour.
module board_move_writer
    import board_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 2,
    parameter int unsigned EDGE_ADDR_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          move_valid,
    output logic                          move_ready,
    input  logic                          move_pass,
    input  logic [EDGE_ADDR_BITS-1:0]     move_x,
    input  logic [EDGE_ADDR_BITS-1:0]     move_y,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [2:0]                    result_code,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic                          turn,
    output logic                          game_over,
    output logic [2*EDGE_ADDR_BITS:0]     stone_count,
    output logic                          ram_wr_en,
    output logic [2*EDGE_ADDR_BITS-1:0]   ram_wr_addr,
    output logic [DATA_BITS-1:0]          ram_wr_data,
    output logic [2*EDGE_ADDR_BITS-1:0]   ram_rd_addr_1,
    input  logic [DATA_BITS-1:0]          ram_rd_data_1,
    output logic [2*EDGE_ADDR_BITS-1:0]   ram_rd_addr_2,
    input  logic [DATA_BITS-1:0]          ram_rd_data_2
);

    localparam int unsigned AW = 2 * EDGE_ADDR_BITS;
    localparam int unsigned CW = AW + 1;

    state_e                    state_q, state_d;
    logic [EDGE_ADDR_BITS-1:0] mv_x_q, mv_y_q;
    logic [DATA_BITS-1:0]      tgt_q;
    logic [2:0]                code_q, code_d;
    logic                      turn_q, turn_d;
    logic                      over_q, over_d;
    logic                      last_pass_q, last_pass_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      accept;
    logic                      sweep_en, sweep_done;
    logic [AW-1:0]             sweep_addr;
    logic [NBR_ADDR_W:0]       nb1, nb2;
    logic                      tgt_empty;
`ifdef SUICIDE_CHECK_EN
    logic                      liberty_q, liberty_d;
`endif

    assign sweep_en  = (state_q == ST_CLEAR);
    assign accept    = (state_q == ST_IDLE) && move_valid && !clear_req;
    assign tgt_empty = (tgt_q == DATA_BITS'(CELL_EMPTY));

    board_clear_sweeper #(.ADDR_BITS(AW)) u_sweeper (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sweep_en),
        .addr  (sweep_addr),
        .done  (sweep_done)
    );

    always_comb begin
        nb1 = nbr_addr(32'(mv_x_q), 32'(mv_y_q), DIR_C, EDGE_ADDR_BITS);
        nb2 = nb1;
        case (state_q)
            ST_LOOK0: nb2 = nbr_addr(32'(mv_x_q), 32'(mv_y_q), DIR_N, EDGE_ADDR_BITS);
            ST_LOOK1: begin
                nb1 = nbr_addr(32'(mv_x_q), 32'(mv_y_q), DIR_S, EDGE_ADDR_BITS);
                nb2 = nbr_addr(32'(mv_x_q), 32'(mv_y_q), DIR_W, EDGE_ADDR_BITS);
            end
            ST_LOOK2: nb1 = nbr_addr(32'(mv_x_q), 32'(mv_y_q), DIR_E, EDGE_ADDR_BITS);
            default: ;
        endcase
        ram_rd_addr_1 = AW'(nb1);
        ram_rd_addr_2 = AW'(nb2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        turn_d       = turn_q;
        over_d       = over_q;
        last_pass_d  = last_pass_q;
        count_d      = count_q;
        move_ready   = 1'b0;
        result_valid = 1'b0;
        clear_busy   = 1'b0;
        ram_wr_en    = 1'b0;
        ram_wr_addr  = {mv_y_q, mv_x_q};
        ram_wr_data  = turn_q ? DATA_BITS'(CELL_WHITE) : DATA_BITS'(CELL_BLACK);
`ifdef SUICIDE_CHECK_EN
        liberty_d    = liberty_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                clear_busy  = 1'b1;
                // State sits in CLEAR while reset is held; keep the strobe quiet until release.
                ram_wr_en   = rst_n;
                ram_wr_addr = sweep_addr;
                ram_wr_data = '0;
                if (sweep_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                move_ready = 1'b1;
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    turn_d      = 1'b0;
                    over_d      = 1'b0;
                    last_pass_d = 1'b0;
                    count_d     = '0;
                end else if (move_valid) begin
                    if (over_q) begin
                        code_d  = RES_GAME_OVER;
                        state_d = ST_RESP;
                    end else if (move_pass) begin
                        code_d      = RES_PASS;
                        turn_d      = ~turn_q;
                        over_d      = last_pass_q;
                        last_pass_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_LOOK0;
                    end
                end
            end
            ST_LOOK0: begin
`ifdef SUICIDE_CHECK_EN
                liberty_d = nb2[NBR_ADDR_W] && (ram_rd_data_2 == DATA_BITS'(CELL_EMPTY));
`endif
                state_d = ST_LOOK1;
            end
            ST_LOOK1: begin
`ifdef SUICIDE_CHECK_EN
                liberty_d = liberty_q
                          | (nb1[NBR_ADDR_W] && (ram_rd_data_1 == DATA_BITS'(CELL_EMPTY)))
                          | (nb2[NBR_ADDR_W] && (ram_rd_data_2 == DATA_BITS'(CELL_EMPTY)));
`endif
                state_d = ST_LOOK2;
            end
            ST_LOOK2: begin
`ifdef SUICIDE_CHECK_EN
                liberty_d = liberty_q
                          | (nb1[NBR_ADDR_W] && (ram_rd_data_1 == DATA_BITS'(CELL_EMPTY)));
`endif
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_RESP;
                if (!tgt_empty) begin
                    code_d = RES_OCCUPIED;
`ifdef SUICIDE_CHECK_EN
                end else if (!liberty_q) begin
                    code_d = RES_SUICIDE;
`endif
                end else begin
                    code_d      = RES_OK;
                    ram_wr_en   = 1'b1;
                    count_d     = count_q + CW'(1);
                    turn_d      = ~turn_q;
                    last_pass_d = 1'b0;
                end
            end
            ST_RESP: begin
                result_valid = 1'b1;
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            tgt_q       <= '0;
            code_q      <= RES_OK;
            turn_q      <= 1'b0;
            over_q      <= 1'b0;
            last_pass_q <= 1'b0;
            count_q     <= '0;
`ifdef SUICIDE_CHECK_EN
            liberty_q   <= 1'b0;
`endif
        end else begin
            code_q      <= code_d;
            turn_q      <= turn_d;
            over_q      <= over_d;
            last_pass_q <= last_pass_d;
            count_q     <= count_d;
`ifdef SUICIDE_CHECK_EN
            liberty_q   <= liberty_d;
`endif
            if (accept) begin
                mv_x_q <= move_x;
                mv_y_q <= move_y;
            end
            // Target is read on port 1 in LOOK0 and again on port 2 in LOOK2.
            if (state_q == ST_LOOK0) begin
                tgt_q <= ram_rd_data_1;
            end else if (state_q == ST_LOOK2) begin
                tgt_q <= ram_rd_data_2;
            end
        end
    end

    assign result_code = code_q;
    assign turn        = turn_q;
    assign game_over   = over_q;
    assign stone_count = count_q;

endmodule

// File: tb/tb_board_move_writer.sv
// Self-checking bench for board_move_writer with a behavioural RAM and Go-rules model.
module tb_board_move_writer;

    localparam int SIDE = 8;
    localparam int NCELL = SIDE * SIDE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_valid = 1'b0, move_pass = 1'b0;
    logic [2:0] move_x = '0, move_y = '0;
    logic       move_ready, result_valid;
    logic       result_ready = 1'b0;
    logic [2:0] result_code;
    logic       clear_req = 1'b0, clear_busy, turn, game_over;
    logic [6:0] stone_count;
    logic       ram_wr_en;
    logic [5:0] ram_wr_addr, ram_rd_addr_1, ram_rd_addr_2;
    logic [1:0] ram_wr_data, ram_rd_data_1, ram_rd_data_2;

    logic [1:0] mem [NCELL];
    logic [5:0] junk_ptr = '0;

    int checks = 0;
    int failures = 0;
    int wa[$];
    int wd[$];
    int board [SIDE][SIDE];
    int m_turn, m_over, m_last, m_count;

    always #5 clk = ~clk;

    board_move_writer #(.DATA_BITS(2), .EDGE_ADDR_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .move_valid(move_valid), .move_ready(move_ready), .move_pass(move_pass),
        .move_x(move_x), .move_y(move_y),
        .result_valid(result_valid), .result_ready(result_ready), .result_code(result_code),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .turn(turn), .game_over(game_over), .stone_count(stone_count),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr_1(ram_rd_addr_1), .ram_rd_data_1(ram_rd_data_1),
        .ram_rd_addr_2(ram_rd_addr_2), .ram_rd_data_2(ram_rd_data_2)
    );

    // RAM fills with junk while reset is held so the sweep has something to erase.
    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            mem[junk_ptr] <= 2'($urandom);
            junk_ptr <= junk_ptr + 6'd1;
        end else if (ram_wr_en === 1'b1) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
    end
    assign ram_rd_data_1 = mem[ram_rd_addr_1];
    assign ram_rd_data_2 = mem[ram_rd_addr_2];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ram_wr_en === 1'b1) begin
            wa.push_back(int'(ram_wr_addr));
            wd.push_back(int'(ram_wr_data));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (board[i, j]) board[i][j] = 0;
        m_turn = 0; m_over = 0; m_last = 0; m_count = 0;
    endtask

    task automatic model_move(input bit pass, input int x, input int y,
                              output int code, output bit wr, output int waddr, output int wdata);
`ifdef SUICIDE_CHECK_EN
        int libs;
`endif
        wr = 1'b0; waddr = 0; wdata = 0;
        if (m_over != 0) code = 4;
        else if (pass) begin
            code = 3;
            m_turn = 1 - m_turn;
            if (m_last != 0) m_over = 1;
            m_last = 1;
        end else if (board[y][x] != 0) code = 1;
        else begin
            code = 0;
`ifdef SUICIDE_CHECK_EN
            libs = 0;
            if (y > 0        && board[y-1][x] == 0) libs++;
            if (y < SIDE - 1 && board[y+1][x] == 0) libs++;
            if (x > 0        && board[y][x-1] == 0) libs++;
            if (x < SIDE - 1 && board[y][x+1] == 0) libs++;
            if (libs == 0) code = 2;
`endif
            if (code == 0) begin
                wr = 1'b1;
                waddr = y * SIDE + x;
                wdata = m_turn + 1;
                board[y][x] = m_turn + 1;
                m_count++;
                m_turn = 1 - m_turn;
                m_last = 0;
            end
        end
    endtask

    task automatic sweep_check(input string tag);
        int n, bad, nz;
        n = 0;
        while (move_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(move_ready), 1);
        chk({tag, "_nwrites"}, wa.size(), NCELL);
        bad = 0;
        foreach (wa[i]) if (wa[i] != i || wd[i] != 0) bad++;
        chk({tag, "_order"}, bad, 0);
        nz = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== 2'd0) nz++;
        chk({tag, "_mem_clear"}, nz, 0);
        chk({tag, "_busy"}, 32'(clear_busy), 0);
        chk({tag, "_turn"}, 32'(turn), 0);
        chk({tag, "_over"}, 32'(game_over), 0);
        chk({tag, "_count"}, 32'(stone_count), 0);
        model_clear();
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        move_valid = 1'b0; clear_req = 1'b0; result_ready = 1'b0;
        repeat (cyc) @(negedge clk);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_move_ready", 32'(move_ready), 0);
        chk("rst_wr_en", 32'(ram_wr_en), 0);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_count", 32'(stone_count), 0);
        @(posedge clk);
        #2;
        wa.delete(); wd.delete();
        rst_n = 1'b1;
        sweep_check("sweep");
    endtask

    task automatic do_move(input bit pass, input int x, input int y, input int hold, input bit abort);
        int code, lat, waddr, wdata;
        bit wr, fast;
        fast = (m_over != 0) || pass;
        model_move(pass, x, y, code, wr, waddr, wdata);
        chk("move_ready_idle", 32'(move_ready), 1);
        wa.delete(); wd.delete();
        move_valid = 1'b1; move_pass = pass; move_x = 3'(x); move_y = 3'(y);
        @(negedge clk);
        move_valid = 1'b0; move_pass = 1'($urandom); move_x = 3'($urandom); move_y = 3'($urandom);
        lat = 1;
        while (result_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, fast ? 1 : 5);
        chk("code", 32'(result_code), code);
        chk("nwrites", wa.size(), 32'(wr));
        if (wr && wa.size() == 1) begin
            chk("wr_addr", wa[0], waddr);
            chk("wr_data", wd[0], wdata);
        end
        chk("turn", 32'(turn), m_turn);
        chk("game_over", 32'(game_over), m_over);
        chk("stone_count", 32'(stone_count), m_count);
        chk("busy_not_ready", 32'(move_ready), 0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(result_valid), 1);
            chk("hold_code", 32'(result_code), code);
            chk("hold_not_ready", 32'(move_ready), 0);
        end
        if (abort) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort_valid_drop", 32'(result_valid), 0);
            chk("abort_busy", 32'(clear_busy), 1);
            do_reset(5);
        end else begin
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk("released", 32'(result_valid), 0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        model_clear();
        #3;
        do_reset(70);

        do_move(1'b0, 3, 4, 0, 1'b0);
        do_move(1'b0, 3, 4, 1, 1'b0);

        repeat (40) begin
            do_move($urandom_range(0, 9) == 0, $urandom_range(0, SIDE - 1),
                    $urandom_range(0, SIDE - 1), $urandom_range(0, 2), 1'b0);
        end

        // clear_req and move_valid together: clear wins, move is dropped
        @(negedge clk);
        chk("coll_ready", 32'(move_ready), 1);
        wa.delete(); wd.delete();
        clear_req = 1'b1; move_valid = 1'b1; move_pass = 1'b0; move_x = 3'd2; move_y = 3'd2;
        @(negedge clk);
        clear_req = 1'b0; move_valid = 1'b0;
        chk("coll_busy", 32'(clear_busy), 1);
        chk("coll_no_result", 32'(result_valid), 0);
        sweep_check("coll");
        chk("coll_idle_no_result", 32'(result_valid), 0);

        do_move(1'b0, 1, 0, 0, 1'b0);
        do_move(1'b0, 0, 1, 0, 1'b0);
        do_move(1'b0, 0, 0, 0, 1'b0);

        do_move(1'b1, 0, 0, 0, 1'b0);
        do_move(1'b1, 0, 0, 0, 1'b0);
        do_move(1'b0, 0, 0, 0, 1'b0);

        do_move(1'b0, 5, 5, 10, 1'b1);
        do_move(1'b0, 7, 7, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
